hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_pkg.sv | 18 +
 rtl/hazard_scoreboard_if.sv | 39 +++
 rtl/hazard_scoreboard_fwd_select.sv | 24 ++
 rtl/hazard_scoreboard.sv | 97 +++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the decode-stage hazard scoreboard: forward selects
// and latency classes.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG    = 2'b00,
    FWD_EX_MEM = 2'b01,
    FWD_MEM_WB = 2'b10
  } fwd_sel_e;

  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;

  function automatic int cnt_width(input int max_lat);
    return $clog2(max_lat + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/execute pipeline signals seen by the hazard scoreboard, plus its
// stall, issue and forward-select results.
interface hazard_scoreboard_if #(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 3
);
  logic                              id_valid;
  logic                              id_flush;
  logic [NUM_SRC-1:0][ADDR_W-1:0]    id_rs;
  logic [NUM_SRC-1:0]                id_rs_used;
  logic                              id_is_branch;
  logic [ADDR_W-1:0]                 id_rd;
  logic                              id_we;
  logic [CNT_W-1:0]                  id_lat;
  logic [NUM_SRC-1:0][ADDR_W-1:0]    ex_rs;
  logic [ADDR_W-1:0]                 ex_mem_rd;
  logic                              ex_mem_we;
  logic [ADDR_W-1:0]                 mem_wb_rd;
  logic                              mem_wb_we;
  logic                              stall;
  logic                              issue;
  logic [NUM_SRC-1:0][1:0]           fwd_ex;
  logic [NUM_SRC-1:0][1:0]           fwd_id;
  logic                              busy;
  logic [15:0]                       stall_count;

  modport master (
    output id_valid, id_flush, id_rs, id_rs_used, id_is_branch, id_rd, id_we,
           id_lat, ex_rs, ex_mem_rd, ex_mem_we, mem_wb_rd, mem_wb_we,
    input  stall, issue, fwd_ex, fwd_id, busy, stall_count
  );

  modport slave (
    input  id_valid, id_flush, id_rs, id_rs_used, id_is_branch, id_rd, id_we,
           id_lat, ex_rs, ex_mem_rd, ex_mem_we, mem_wb_rd, mem_wb_we,
    output stall, issue, fwd_ex, fwd_id, busy, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard_fwd_select.sv
// One operand's bypass select: EX_MEM beats MEM_WB, x0 never forwards.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] ex_mem_rd,
  input  logic              ex_mem_we,
  input  logic [ADDR_W-1:0] mem_wb_rd,
  input  logic              mem_wb_we,
  output fwd_sel_e          sel
);
  always_comb begin
    sel = FWD_REG;
    if (en) begin
      if (ex_mem_we && ex_mem_rd != '0 && ex_mem_rd == rs)
        sel = FWD_EX_MEM;
      else if (mem_wb_we && mem_wb_rd != '0 && mem_wb_rd == rs)
        sel = FWD_MEM_WB;
    end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register result-latency scoreboard: stalls decode on RAW/WAW hazards
// and produces EX and branch-in-decode bypass selects.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int MAX_LAT = 4
) (
  input  logic          clock,
  input  logic          reset,
  hazard_scoreboard_if.slave bus
);
  localparam int CNT_W = cnt_width(MAX_LAT);
  localparam int NREG  = 1 << ADDR_W;

  logic [NREG-1:0][CNT_W-1:0] cnt_q;
  logic [15:0]                stall_cnt_q;
  logic [CNT_W-1:0]           lat_eff;
  logic [NUM_SRC-1:0]         src_haz;
  logic                       waw_haz;
  logic                       live;
  logic                       hazard;
  logic                       wr_en;

  // A zero latency would never block anything; treat it as a plain ALU op.
  assign lat_eff = (bus.id_lat == '0) ? CNT_W'(LAT_ALU) : bus.id_lat;

  // ALU results are forwardable to EX when cnt==1, but a branch resolving
  // in decode needs the value one cycle earlier, so it waits for cnt==0.
  always_comb begin
    src_haz = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (bus.id_rs_used[s] && bus.id_rs[s] != '0) begin
        if (bus.id_is_branch)
          src_haz[s] = (cnt_q[bus.id_rs[s]] != '0);
        else
          src_haz[s] = (cnt_q[bus.id_rs[s]] > CNT_W'(LAT_ALU));
      end
    end
  end

  assign waw_haz = bus.id_we && bus.id_rd != '0 && (cnt_q[bus.id_rd] > lat_eff);
  assign live    = bus.id_valid && !bus.id_flush;
  assign hazard  = (|src_haz) || waw_haz;
  assign wr_en   = bus.issue && bus.id_we && bus.id_rd != '0;

  assign bus.stall       = live && hazard;
  assign bus.issue       = live && !hazard;
  assign bus.busy        = |cnt_q;
  assign bus.stall_count = stall_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (r == 0)
          cnt_q[r] <= '0;
        else if (wr_en && bus.id_rd == ADDR_W'(r))
          cnt_q[r] <= lat_eff;
        else if (cnt_q[r] != '0)
          cnt_q[r] <= cnt_q[r] - CNT_W'(1);
      end
      if (bus.stall && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  fwd_sel_e fex_sel [NUM_SRC];
  fwd_sel_e fid_sel [NUM_SRC];

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_fwd
    fwd_select #(.ADDR_W(ADDR_W)) u_ex (
      .en        (1'b1),
      .rs        (bus.ex_rs[s]),
      .ex_mem_rd (bus.ex_mem_rd),
      .ex_mem_we (bus.ex_mem_we),
      .mem_wb_rd (bus.mem_wb_rd),
      .mem_wb_we (bus.mem_wb_we),
      .sel       (fex_sel[s])
    );
    fwd_select #(.ADDR_W(ADDR_W)) u_id (
      .en        (bus.id_is_branch && bus.id_rs_used[s]),
      .rs        (bus.id_rs[s]),
      .ex_mem_rd (bus.ex_mem_rd),
      .ex_mem_we (bus.ex_mem_we),
      .mem_wb_rd (bus.mem_wb_rd),
      .mem_wb_we (bus.mem_wb_we),
      .sel       (fid_sel[s])
    );
    assign bus.fwd_ex[s] = fex_sel[s];
    assign bus.fwd_id[s] = fid_sel[s];
  end

endmodule
